// File: rtl/pipe_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Interface : pipe_scoreboard_if
// Purpose   : ID-stage issue, long-unit completion and writeback to the scoreboard
// Revision  : 1.0
// ============================================================================
interface pipe_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int IDX_W = $clog2(NREGS),
  parameter int LAT_W = 2
);
  logic             issue_valid_i;
  logic             issue_use_rs1_i;
  logic             issue_use_rs2_i;
  logic [IDX_W-1:0] issue_rs1_i;
  logic [IDX_W-1:0] issue_rs2_i;
  logic             issue_wr_i;
  logic [IDX_W-1:0] issue_rd_i;
  logic [LAT_W-1:0] issue_lat_i;
  logic             issue_long_i;
  logic             flush_i;
  logic             complete_valid_i;
  logic [IDX_W-1:0] complete_rd_i;
  logic             wb_valid_i;
  logic [IDX_W-1:0] wb_rd_i;
  logic             stall_o;
  logic [1:0]       fwd_a_o;
  logic [1:0]       fwd_b_o;
  logic [NREGS-1:0] busy_o;
  logic             long_pending_o;

  modport master (
    output issue_valid_i, issue_use_rs1_i, issue_use_rs2_i, issue_rs1_i, issue_rs2_i,
    output issue_wr_i, issue_rd_i, issue_lat_i, issue_long_i, flush_i,
    output complete_valid_i, complete_rd_i, wb_valid_i, wb_rd_i,
    input  stall_o, fwd_a_o, fwd_b_o, busy_o, long_pending_o
  );

  modport slave (
    input  issue_valid_i, issue_use_rs1_i, issue_use_rs2_i, issue_rs1_i, issue_rs2_i,
    input  issue_wr_i, issue_rd_i, issue_lat_i, issue_long_i, flush_i,
    input  complete_valid_i, complete_rd_i, wb_valid_i, wb_rd_i,
    output stall_o, fwd_a_o, fwd_b_o, busy_o, long_pending_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scoreboard
// Purpose  : ID->EX register scoreboard producing the ID stall and EX forward selects
// Revision : 1.0
// ============================================================================
module pipe_scoreboard #(
  parameter int NREGS = 32,
  parameter int IDX_W = $clog2(NREGS),
  parameter int LAT_W = 2
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  pipe_scoreboard_if.slave sb
);
  localparam logic [1:0] c_sel_rf  = 2'b00;
  localparam logic [1:0] c_sel_mem = 2'b01;
  localparam logic [1:0] c_sel_wb  = 2'b10;
  localparam logic [1:0] c_age_wb  = 2'd2;

  logic [1:0]       r_cnt [NREGS];
  logic [1:0]       r_age [NREGS];
  logic [LAT_W-1:0] r_rem [NREGS];
  logic             r_lng [NREGS];
  logic             r_long_pending;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;

  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_haz;
  logic [NREGS-1:0] w_dec;
  logic [NREGS-1:0] w_cpl;
  logic [NREGS-1:0] w_inc;
  logic             w_haz_rs1;
  logic             w_haz_rs2;
  logic             w_waw_long;
  logic             w_stall;
  logic             w_accept;
  logic [1:0]       w_sel_a;
  logic [1:0]       w_sel_b;

  // Entry 0 is never written, so x0 always reads as idle.
  always_comb begin
    w_busy = '0;
    w_haz  = '0;
    w_dec  = '0;
    w_cpl  = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_busy[r] = (r_cnt[r] != 2'd0);
      w_haz[r]  = w_busy[r] && (r_lng[r] || (r_rem[r] != '0) || (r_age[r] == c_age_wb));
      w_dec[r]  = sb.wb_valid_i && (sb.wb_rd_i == IDX_W'(r)) && w_busy[r];
      w_cpl[r]  = sb.complete_valid_i && (sb.complete_rd_i == IDX_W'(r)) && r_lng[r];
    end
  end

  assign w_haz_rs1  = sb.issue_use_rs1_i && (sb.issue_rs1_i != '0) && w_haz[sb.issue_rs1_i];
  assign w_haz_rs2  = sb.issue_use_rs2_i && (sb.issue_rs2_i != '0) && w_haz[sb.issue_rs2_i];
  assign w_waw_long = sb.issue_wr_i && w_busy[sb.issue_rd_i] && r_lng[sb.issue_rd_i];
  assign w_stall    = sb.issue_valid_i && !sb.flush_i &&
                      (w_haz_rs1 || w_haz_rs2 || w_waw_long || (sb.issue_long_i && r_long_pending));
  assign w_accept   = sb.issue_valid_i && !sb.flush_i && !w_stall;

  always_comb begin
    w_inc = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_inc[r] = w_accept && sb.issue_wr_i && (sb.issue_rd_i == IDX_W'(r));
    end
  end

  // Age 0 = producer now in EX (reader will see it in MEM); age 1 = producer in MEM.
  always_comb begin
    w_sel_a = c_sel_rf;
    w_sel_b = c_sel_rf;
    if (sb.issue_use_rs1_i && w_busy[sb.issue_rs1_i]) begin
      if (r_age[sb.issue_rs1_i] == 2'd0)      w_sel_a = c_sel_mem;
      else if (r_age[sb.issue_rs1_i] == 2'd1) w_sel_a = c_sel_wb;
    end
    if (sb.issue_use_rs2_i && w_busy[sb.issue_rs2_i]) begin
      if (r_age[sb.issue_rs2_i] == 2'd0)      w_sel_b = c_sel_mem;
      else if (r_age[sb.issue_rs2_i] == 2'd1) w_sel_b = c_sel_wb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r] <= 2'd0;
        r_age[r] <= 2'd0;
        r_rem[r] <= '0;
        r_lng[r] <= 1'b0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_inc[r] && !w_dec[r])      r_cnt[r] <= r_cnt[r] + 2'd1;
        else if (w_dec[r] && !w_inc[r]) r_cnt[r] <= r_cnt[r] - 2'd1;

        if (w_inc[r]) begin
          r_age[r] <= 2'd0;
          r_rem[r] <= sb.issue_lat_i;
          r_lng[r] <= sb.issue_long_i;
        end else if (w_cpl[r]) begin
          r_age[r] <= 2'd0;
          r_rem[r] <= '0;
          r_lng[r] <= 1'b0;
        end else if (w_busy[r]) begin
          if (r_age[r] != c_age_wb) r_age[r] <= r_age[r] + 2'd1;
          if (r_rem[r] != '0)       r_rem[r] <= r_rem[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_long_pending <= 1'b0;
      r_fwd_a        <= c_sel_rf;
      r_fwd_b        <= c_sel_rf;
    end else begin
      if (w_accept && sb.issue_long_i) r_long_pending <= 1'b1;
      else if (|w_cpl)                 r_long_pending <= 1'b0;
      r_fwd_a <= w_accept ? w_sel_a : c_sel_rf;
      r_fwd_b <= w_accept ? w_sel_b : c_sel_rf;
    end
  end

  // Only EX, MEM and WB can hold writers, so a fourth one means a broken pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 1; r < NREGS; r++) begin
        assert (!(w_inc[r] && !w_dec[r] && (r_cnt[r] == 2'd3)));
      end
    end
  end

  assign sb.stall_o        = w_stall;
  assign sb.fwd_a_o        = r_fwd_a;
  assign sb.fwd_b_o        = r_fwd_b;
  assign sb.busy_o         = w_busy;
  assign sb.long_pending_o = r_long_pending;
endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_scoreboard
// Purpose  : directed vector table plus randomized run against a timestamp model
// Revision : 1.0
// ============================================================================
module tb_pipe_scoreboard;
  localparam int NREGS = 32;
  localparam int IDX_W = 5;
  localparam int LAT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_scoreboard_if #(.NREGS(NREGS), .IDX_W(IDX_W), .LAT_W(LAT_W)) sb_if ();

  pipe_scoreboard #(.NREGS(NREGS), .IDX_W(IDX_W), .LAT_W(LAT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .sb    (sb_if)
  );

  typedef struct {
    bit rn, v, fl, u1, u2, wr, lg, cv, wbv;
    logic [IDX_W-1:0] r1, r2, rd, crd, wbrd;
    logic [LAT_W-1:0] lat;
    bit st, lp;
    logic [1:0] fa, fb;
    logic [31:0] busy;
  } vec_t;

  typedef struct {
    int rd;
    int t_iss;
    int t_base;
    int lat;
    bit lng;
  } wr_t;

  vec_t tbl[$];
  wr_t  wq[$];
  bit   m_lp;
  int   now;
  logic [1:0] exp_fa, exp_fb;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int rn, v, fl, u1, r1, u2, r2, wr, rd, lat, lg,
                              cv, crd, wbv, wbrd, st, fa, fb, busy, lp);
    vec_t m;
    m.rn = 1'(rn); m.v = 1'(v); m.fl = 1'(fl); m.u1 = 1'(u1); m.u2 = 1'(u2);
    m.wr = 1'(wr); m.lg = 1'(lg); m.cv = 1'(cv); m.wbv = 1'(wbv);
    m.r1 = IDX_W'(r1); m.r2 = IDX_W'(r2); m.rd = IDX_W'(rd); m.crd = IDX_W'(crd); m.wbrd = IDX_W'(wbrd);
    m.lat = LAT_W'(lat); m.st = 1'(st); m.lp = 1'(lp); m.fa = 2'(fa); m.fb = 2'(fb);
    m.busy = 32'(busy);
    return m;
  endfunction

  task automatic drive(input vec_t m);
    rst_n                  = m.rn;
    sb_if.issue_valid_i    = m.v;
    sb_if.flush_i          = m.fl;
    sb_if.issue_use_rs1_i  = m.u1;
    sb_if.issue_rs1_i      = m.r1;
    sb_if.issue_use_rs2_i  = m.u2;
    sb_if.issue_rs2_i      = m.r2;
    sb_if.issue_wr_i       = m.wr;
    sb_if.issue_rd_i       = m.rd;
    sb_if.issue_lat_i      = m.lat;
    sb_if.issue_long_i     = m.lg;
    sb_if.complete_valid_i = m.cv;
    sb_if.complete_rd_i    = m.crd;
    sb_if.wb_valid_i       = m.wbv;
    sb_if.wb_rd_i          = m.wbrd;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference model: each in-flight write is a timestamped record; newest record per register wins.
  function automatic int newest(input int rd);
    int k = -1;
    foreach (wq[i]) if (wq[i].rd == rd) k = i;
    return k;
  endfunction

  function automatic int age_of(input int k);
    int a = now - wq[k].t_base - 1;
    return (a > 2) ? 2 : a;
  endfunction

  function automatic bit m_haz(input bit en, input int rs);
    int k;
    int rem;
    if (!en || rs == 0) return 1'b0;
    k = newest(rs);
    if (k < 0) return 1'b0;
    rem = wq[k].lat - (now - wq[k].t_iss - 1);
    return wq[k].lng || (rem > 0) || (age_of(k) == 2);
  endfunction

  function automatic logic [1:0] m_sel(input bit en, input int rs);
    int k;
    if (!en || rs == 0) return 2'b00;
    k = newest(rs);
    if (k < 0) return 2'b00;
    case (age_of(k))
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    //            rn v fl u1 r1 u2 r2 wr rd lat lg cv crd wbv wbrd st fa fb busy   lp
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h0,   0)); // reset
    tbl.push_back(mk(1,1,0, 1,0, 1,0, 1,1, 0,0, 0,0, 0,0, 0, 0,0, 'h2,   0)); // add x1
    tbl.push_back(mk(1,1,0, 1,1, 1,1, 1,2, 0,0, 0,0, 0,0, 0, 1,1, 'h6,   0)); // add x2,x1,x1
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h6,   0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,1, 0, 0,0, 'h4,   0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,2, 0, 0,0, 'h0,   0));
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,5, 1,0, 0,0, 0,0, 0, 0,0, 'h20,  0)); // lw x5
    tbl.push_back(mk(1,1,0, 1,5, 1,0, 1,6, 0,0, 0,0, 0,0, 1, 0,0, 'h20,  0)); // load-use stall
    tbl.push_back(mk(1,1,0, 1,5, 1,0, 1,6, 0,0, 0,0, 0,0, 0, 2,0, 'h60,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,5, 0, 0,0, 'h40,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h40,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,6, 0, 0,0, 'h0,   0));
    tbl.push_back(mk(1,1,0, 1,0, 1,0, 1,7, 0,1, 0,0, 0,0, 0, 0,0, 'h80,  1)); // div x7
    tbl.push_back(mk(1,1,0, 1,7, 1,0, 1,8, 0,0, 0,0, 0,0, 1, 0,0, 'h80,  1));
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,9, 0,1, 0,0, 0,0, 1, 0,0, 'h80,  1)); // second long op
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,7, 0,0, 0,0, 0,0, 1, 0,0, 'h80,  1)); // WAW vs long
    tbl.push_back(mk(1,1,0, 1,7, 1,0, 1,8, 0,0, 0,0, 0,0, 1, 0,0, 'h80,  1));
    tbl.push_back(mk(1,1,0, 1,7, 1,0, 1,8, 0,0, 1,7, 0,0, 1, 0,0, 'h80,  0)); // completion
    tbl.push_back(mk(1,1,0, 1,7, 1,0, 1,8, 0,0, 0,0, 0,0, 0, 1,0, 'h180, 0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 1,8, 0,0, 0, 0,0, 'h180, 0)); // stray completion
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,7, 0, 0,0, 'h100, 0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,8, 0, 0,0, 'h0,   0));
    tbl.push_back(mk(1,1,0, 1,0, 1,0, 1,0, 0,0, 0,0, 0,0, 0, 0,0, 'h0,   0)); // write x0
    tbl.push_back(mk(1,1,1, 1,0, 0,0, 1,3, 0,0, 0,0, 0,0, 0, 0,0, 'h0,   0)); // flushed
    tbl.push_back(mk(1,1,0, 1,3, 0,0, 1,4, 0,0, 0,0, 0,0, 0, 0,0, 'h10,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h10,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h10,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,4, 0, 0,0, 'h0,   0));
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,1, 0,0, 0,0, 0,0, 0, 0,0, 'h2,   0)); // add x1
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h2,   0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h2,   0));
    tbl.push_back(mk(1,1,0, 1,1, 0,0, 0,0, 0,0, 0,0, 1,1, 1, 0,0, 'h0,   0)); // writer in WB
    tbl.push_back(mk(1,1,0, 1,1, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h0,   0));
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,1, 0,0, 0,0, 0,0, 0, 0,0, 'h2,   0));
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,2, 0,0, 0,0, 0,0, 0, 0,0, 'h6,   0));
    tbl.push_back(mk(1,1,0, 1,0, 0,0, 1,3, 0,1, 0,0, 0,0, 0, 0,0, 'hE,   1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h0,   0)); // mid-flight reset
    tbl.push_back(mk(1,1,0, 1,3, 0,0, 1,4, 0,0, 0,0, 0,0, 0, 0,0, 'h10,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h10,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 'h10,  0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,4, 0, 0,0, 'h0,   0));

    drive(mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0));
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 check($sformatf("v%0d stall", i), 32'(sb_if.stall_o), 32'(tbl[i].st));
      @(posedge clk);
      #1;
      check($sformatf("v%0d fwd_a", i), 32'(sb_if.fwd_a_o), 32'(tbl[i].fa));
      check($sformatf("v%0d fwd_b", i), 32'(sb_if.fwd_b_o), 32'(tbl[i].fb));
      check($sformatf("v%0d busy", i), sb_if.busy_o, tbl[i].busy);
      check($sformatf("v%0d long_pending", i), 32'(sb_if.long_pending_o), 32'(tbl[i].lp));
    end

    wq.delete();
    m_lp = 1'b0;
    now = 0;
    exp_fa = 2'b00;
    exp_fb = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit rn, v, fl, u1, u2, wr, lg, cv, wbv, stl, acc, clash;
      int r1, r2, rd, lat, crd, wbrd, kl, kd, kw;
      logic [31:0] mb;

      @(negedge clk);
      mb = '0;
      foreach (wq[i]) mb[wq[i].rd] = 1'b1;
      check($sformatf("r%0d busy", cyc), sb_if.busy_o, mb);
      check($sformatf("r%0d long_pending", cyc), 32'(sb_if.long_pending_o), 32'(m_lp));
      check($sformatf("r%0d fwd_a", cyc), 32'(sb_if.fwd_a_o), 32'(exp_fa));
      check($sformatf("r%0d fwd_b", cyc), 32'(sb_if.fwd_b_o), 32'(exp_fb));

      rn  = (cyc != 0) && (cyc != 1500);
      v   = ($urandom % 4) != 0;
      fl  = ($urandom % 8) == 0;
      u1  = $urandom % 2;
      u2  = $urandom % 2;
      r1  = $urandom_range(0, 3);
      r2  = $urandom_range(0, 3);
      wr  = ($urandom % 4) != 0;
      rd  = $urandom_range(0, 3);
      lat = (($urandom % 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      lg  = wr && (rd != 0) && (($urandom % 10) == 0);

      kd  = newest(rd);
      stl = v && !fl && (m_haz(u1, r1) || m_haz(u2, r2) ||
                         (wr && rd != 0 && kd >= 0 && wq[kd].lng) || (lg && m_lp));
      acc = rn && v && !fl && !stl;

      wbv = 1'b0; wbrd = 0; kw = -1;
      foreach (wq[i]) if (!wq[i].lng && wq[i].t_base + 3 == now) begin wbv = 1'b1; wbrd = wq[i].rd; kw = i; end

      // A completion here writes back at now+3, which must not collide with a new issue's writeback.
      cv = 1'b0; crd = 0; kl = -1;
      foreach (wq[i]) if (wq[i].lng) kl = i;
      if (m_lp && kl >= 0 && ($urandom % 4) == 0) begin
        clash = acc && wr && (rd != 0);
        if (!clash) begin cv = 1'b1; crd = wq[kl].rd; end
      end else if (!m_lp && ($urandom % 16) == 0) begin
        cv = 1'b1; crd = $urandom_range(0, 3);
      end

      drive(mk(rn, v, fl, u1, r1, u2, r2, wr, rd, lat, lg, cv, crd, wbv, wbrd, 0, 0, 0, 0, 0));
      #1 check($sformatf("r%0d stall", cyc), 32'(sb_if.stall_o), 32'(stl));

      if (!rn) begin
        wq.delete();
        m_lp = 1'b0;
        exp_fa = 2'b00;
        exp_fb = 2'b00;
      end else begin
        exp_fa = acc ? m_sel(u1, r1) : 2'b00;
        exp_fb = acc ? m_sel(u2, r2) : 2'b00;
        if (cv && m_lp && kl >= 0) begin
          wq[kl].lng = 1'b0;
          wq[kl].lat = 0;
          wq[kl].t_base = now;
          m_lp = 1'b0;
        end
        if (kw >= 0) wq.delete(kw);
        if (acc && wr && rd != 0) wq.push_back('{rd: rd, t_iss: now, t_base: now, lat: lat, lng: lg});
        if (acc && lg) m_lp = 1'b1;
      end
      now++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
